// File: rtl/soc_system_buttons_ctrl.sv
`default_nettype none
// soc_system_buttons_ctrl: Avalon-MM push-button controller with synchronizer, edge capture and irq.
// Optional per-button debounce counters are built when SOC_BUTTONS_DEBOUNCE_EN is defined. Rev 1.0
module soc_system_buttons_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_POL  = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] polarity;
    logic [WIDTH-1:0] event_hit;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rd_mux;
    logic             reg_wr;
    logic             unused;

    // Reads have no side effects, so the read strobe carries no information.
    assign unused    = ^{read, writedata};
    assign reg_wr    = chipselect & write;
    assign w1c       = (reg_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign event_hit = (stable_d & ~stable & ~polarity) | (~stable_d & stable & polarity);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef SOC_BUTTONS_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_debounce
            logic [CNT_W-1:0] cnt;
            logic             level;

            // Any return to the current stable level restarts qualification.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt   <= '0;
                    level <= 1'b1;
                end else if (sync2[i] == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    level <= sync2[i];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign stable[i] = level;
        end
    endgenerate
`else
    localparam int unused_cfg = DEBOUNCE_CYCLES + CNT_W;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= '1;
        end else begin
            stable <= sync2;
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux = stable;
            ADDR_MASK: rd_mux = mask;
            ADDR_EDGE: rd_mux = edge_cap;
            ADDR_POL:  rd_mux = polarity;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d <= '1;
            mask     <= '0;
            polarity <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            stable_d <= stable;
            if (reg_wr && address == ADDR_MASK) begin
                mask <= writedata[WIDTH-1:0];
            end
            if (reg_wr && address == ADDR_POL) begin
                polarity <= writedata[WIDTH-1:0];
            end
            // A new event wins over a simultaneous write-one-to-clear.
            edge_cap <= (edge_cap & ~w1c) | event_hit;
            irq      <= |(edge_cap & mask);
            readdata <= 32'(rd_mux);
        end
    end

endmodule
`default_nettype wire
